// File: rtl/pulse_stretch.sv
// pulse_stretch
//   Turns single-cycle request strobes into fixed-length high windows on
//   signal_stretched. Each window is HIGH_CYCLES long and, when GAP_CYCLES is
//   nonzero, is followed by a forced-low gap of GAP_CYCLES. Requests that
//   arrive while a window or gap is in progress are queued in a saturating
//   counter and served back to back. A request that finds the queue full is
//   dropped and flagged on overflow.
//
// Parameters
//   HIGH_CYCLES  high-window length in cycles        (1..255)
//   GAP_CYCLES   forced-low gap after each window     (0..255)
//   PEND_W       pending-request counter width        (1..8)
//
// Ports
//   clock                sole clock, rising edge
//   reset                asynchronous, active-high
//   signal_single_pulse  request strobe; every sampled-high cycle is a request
//   signal_stretched     registered stretched level
//   busy                 registered, high while not IDLE
//   pending_count        queued requests not yet started
//   overflow             one-cycle strobe per dropped request
module pulse_stretch #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              signal_single_pulse,
    output logic              signal_stretched,
    output logic              busy,
    output logic [PEND_W-1:0] pending_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The counter holds "cycles already spent in this state"; the state ends
    // on the edge where it reaches LAST, so the state lasts exactly N cycles.
    localparam logic [7:0]        HI_LAST  = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0]        GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;
    logic              start;    // a new window begins at this edge
    logic              dec;      // the new window is taken from the queue
    logic              consume;  // the new window is taken from this request
    logic              inc;      // this request goes into the queue

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            signal_stretched <= 1'b0;
            busy             <= 1'b0;
            pending_count    <= '0;
            overflow         <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            signal_stretched <= (state_nxt == HIGH);
            busy             <= (state_nxt != IDLE);
            pending_count    <= pend_nxt;
            overflow         <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        dec       = 1'b0;
        consume   = 1'b0;
        inc       = 1'b0;
        ovf_nxt   = 1'b0;
        pend_nxt  = pending_count;

        case (state)
            IDLE: begin
                if (pending_count != '0 || signal_single_pulse)
                    start = 1'b1;
            end
            HIGH: begin
                if (cnt == HI_LAST) begin
                    if (GAP_CYCLES == 0) begin
                        // No gap: chain straight into the next window so the
                        // output stays high across back-to-back windows.
                        if (pending_count != '0 || signal_single_pulse)
                            start = 1'b1;
                        else begin
                            state_nxt = IDLE;
                            cnt_nxt   = 8'd0;
                        end
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = 8'd0;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    if (pending_count != '0 || signal_single_pulse)
                        start = 1'b1;
                    else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase

        // Older queued requests are served first; a request that arrives on
        // a free edge with an empty queue starts its own window directly.
        if (start) begin
            state_nxt = HIGH;
            cnt_nxt   = 8'd0;
            if (pending_count != '0)
                dec = 1'b1;
            else
                consume = 1'b1;
        end

        inc = signal_single_pulse && !consume;

        // A full queue still accepts a request on an edge that also drains
        // one, so a drop only happens without a coincident decrement.
        if (inc && !dec && pending_count == PEND_MAX)
            ovf_nxt = 1'b1;

        case ({inc && !ovf_nxt, dec})
            2'b10:   pend_nxt = pending_count + PEND_ONE;
            2'b01:   pend_nxt = pending_count - PEND_ONE;
            default: pend_nxt = pending_count;
        endcase
    end

endmodule

// File: tb/tb_pulse_stretch.sv
module tb_pulse_stretch;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req   = 1'b0;

    logic       s0, b0, o0;
    logic [3:0] p0;
    logic       s1, b1, o1;
    logic [1:0] p1;

    // Default configuration.
    pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(4)) dut0 (
        .clock(clock), .reset(reset), .signal_single_pulse(req),
        .signal_stretched(s0), .busy(b0), .pending_count(p0), .overflow(o0)
    );

    // Zero-gap configuration with a small queue, driven by the same stimulus.
    pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(0), .PEND_W(2)) dut1 (
        .clock(clock), .reset(reset), .signal_single_pulse(req),
        .signal_stretched(s1), .busy(b1), .pending_count(p1), .overflow(o1)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    // Reference model: a window is described by its start edge; whether it is
    // still running is plain arithmetic on elapsed edges.
    int hc   [2] = '{4, 4};
    int gc   [2] = '{2, 0};
    int pmax [2] = '{15, 3};
    bit valid[2] = '{0, 0};
    int ws   [2] = '{0, 0};
    int pend [2] = '{0, 0};
    bit ovf  [2] = '{0, 0};

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0;
            ws[k]    = 0;
            pend[k]  = 0;
            ovf[k]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int k, input bit r);
        bit active;
        bit taken;
        active = valid[k] && (t - ws[k]) < (hc[k] + gc[k]);
        taken  = 1'b0;
        ovf[k] = 1'b0;
        if (!active && (pend[k] > 0 || r)) begin
            valid[k] = 1'b1;
            ws[k]    = t;
            if (pend[k] > 0) pend[k] = pend[k] - 1;
            else             taken   = 1'b1;
        end
        if (r && !taken) begin
            if (pend[k] < pmax[k]) pend[k] = pend[k] + 1;
            else                   ovf[k]  = 1'b1;
        end
    endtask

    task automatic check_all();
        int ph;
        bit es, eb;
        for (int k = 0; k < 2; k++) begin
            ph = t - ws[k];
            es = valid[k] && ph < hc[k];
            eb = valid[k] && ph < (hc[k] + gc[k]);
            if (k == 0) begin
                chk("d0_stretched", int'(s0), int'(es));
                chk("d0_busy",      int'(b0), int'(eb));
                chk("d0_pending",   int'(p0), pend[0]);
                chk("d0_overflow",  int'(o0), int'(ovf[0]));
            end else begin
                chk("d1_stretched", int'(s1), int'(es));
                chk("d1_busy",      int'(b1), int'(eb));
                chk("d1_pending",   int'(p1), pend[1]);
                chk("d1_overflow",  int'(o1), int'(ovf[1]));
            end
        end
    endtask

    // One clock: drive the request, advance on the edge, check just after it.
    task automatic step(input bit r);
        req = r;
        @(posedge clock);
        t++;
        if (reset) model_reset();
        else begin
            model_edge(0, r);
            model_edge(1, r);
        end
        #1;
        check_all();
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_s0", int'(s0), 0);
        chk("rst_async_b0", int'(b0), 0);
        chk("rst_async_p0", int'(p0), 0);
        chk("rst_async_o0", int'(o0), 0);
        chk("rst_async_s1", int'(s1), 0);
        chk("rst_async_b1", int'(b1), 0);
        chk("rst_async_p1", int'(p1), 0);
        chk("rst_async_o1", int'(o1), 0);
        model_reset();
        // Requests are ignored while reset is held.
        step(1'b1);
        step(1'b1);
        req = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Single request from IDLE.
        step(1'b1);
        repeat (10) step(1'b0);

        // Three consecutive requests, then a request exactly as the gap ends
        // with two still queued.
        repeat (3) step(1'b1);
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (24) step(1'b0);

        // Held request: queue saturates, drops flagged, backlog drains.
        repeat (40) step(1'b1);
        repeat (95) step(1'b0);

        // Reset in the middle of a high window with three queued.
        repeat (4) step(1'b1);
        mid_reset();
        repeat (20) step(1'b0);

        // Sparse random traffic.
        repeat (300) step($urandom_range(0, 2) == 0);
        // Dense random traffic.
        repeat (200) step($urandom_range(0, 3) != 0);
        repeat (100) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter HIGH_CYCLES, default 4: output high-window length in clock cycles; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: forced-low gap after each window in clock cycles; legal range 0..255.
REQ-003 SHALL have parameter PEND_W, default 4: pending-request counter width; legal range 1..8.
REQ-004 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port signal_single_pulse, input, 1 bit: request strobe, synchronous to clock; every sampled-high cycle is one request.
REQ-007 SHALL have port signal_stretched, output, 1 bit: registered stretched level.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port pending_count, output, PEND_W bits: queued requests not yet started.
REQ-010 SHALL have port overflow, output, 1 bit: one-cycle strobe for each dropped request.

Function
REQ-011 SHALL implement an FSM with states IDLE, HIGH and GAP; all outputs SHALL be registered.
REQ-012 IDLE with request sampled at edge E SHALL enter HIGH at E; signal_stretched SHALL be 1 for exactly HIGH_CYCLES cycles after E; pending_count SHALL stay unchanged.
REQ-013 IDLE with no request and pending_count=0 SHALL remain IDLE with signal_stretched=0.
REQ-014 HIGH SHALL count HIGH_CYCLES cycles, then go to GAP if GAP_CYCLES>0.
REQ-015 If GAP_CYCLES=0, HIGH end SHALL go to HIGH (pending_count decremented) when a request is queued, otherwise to IDLE; signal_stretched SHALL then stay high continuously across back-to-back windows.
REQ-016 GAP SHALL hold signal_stretched=0 for exactly GAP_CYCLES cycles, then enter HIGH with pending_count decremented by 1 if it was >0; otherwise it SHALL enter IDLE.
REQ-017 A request sampled in HIGH or GAP SHALL increment pending_count.
REQ-018 A request coinciding with a pending decrement SHALL leave pending_count unchanged, and no request SHALL be lost.
REQ-019 pending_count SHALL saturate at 2^PEND_W-1 and never wrap; a request arriving at saturation, with no coincident decrement, SHALL be dropped and overflow SHALL be 1 for the cycle after it is sampled.
REQ-020 signal_single_pulse held high for N cycles SHALL count as N requests; no edge detection SHALL be performed.
REQ-021 Window period SHALL be HIGH_CYCLES+GAP_CYCLES cycles under continuous backlog; no window SHALL be shortened or merged except as stated in REQ-015.
REQ-022 Internal window/gap counter SHALL be 8 bits wide; HIGH_CYCLES and GAP_CYCLES SHALL be compared exactly, with no off-by-one.

Reset
REQ-023 Asserting reset SHALL immediately, without a clock edge, force state=IDLE, signal_stretched=0, busy=0, pending_count=0, overflow=0, and internal counter=0.
REQ-024 Queued requests SHALL be discarded on reset; a request sampled at the first edge after reset deassertion SHALL be accepted per REQ-012.
REQ-025 While reset is high, signal_single_pulse SHALL be ignored.

Verification (defaults HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=4)
REQ-026 Single 1-cycle request in IDLE -> signal_stretched high for exactly cycles 1..4 after the sample edge; busy high for 6 cycles; pending_count stays 0; overflow stays 0.
REQ-027 Three requests on consecutive cycles -> pending_count goes 1 then 2; three 4-cycle high windows separated by 2-cycle lows; busy high for 18 cycles; pending_count ends at 0.
REQ-028 Request held high for 40 cycles -> pending_count climbs to 15 and holds without wrapping; overflow strobes once per dropped request; after release, exactly 15 further windows are produced.
REQ-029 Request sampled on the same edge GAP ends with pending_count=2 -> next HIGH starts; pending_count stays 2.
REQ-030 Reset asserted mid-HIGH with pending_count=3 -> all outputs 0 asynchronously; no windows after deassertion until a new request.
REQ-031 GAP_CYCLES=0 with two consecutive requests -> signal_stretched high continuously for 8 cycles, then low; busy falls together with it.
